// File: rtl/counter_sched_pkg.sv
// rtl/counter_sched_pkg.sv - shared FSM state encoding and default sizes for counter_sched
package counter_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_NREQ  = 4;

endpackage

// File: rtl/counter_sched_rr_arbiter.sv
// rtl/counter_sched_rr_arbiter.sv - combinational round-robin pick starting after the last-served index
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   idx
);

  int   k;
  logic found;

  // Scan ptr+1, ptr+2, ... wrapping, so the last-served requester is checked last
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    k     = 0;
    for (int i = 1; i <= NREQ; i++) begin
      k = (int'(ptr) + i) % NREQ;
      if (!found && req[k]) begin
        found  = 1'b1;
        gnt[k] = 1'b1;
        idx    = IW'(k);
      end
    end
  end

endmodule

// File: rtl/counter_sched.sv
// rtl/counter_sched.sv - round-robin shared up/down counter scheduler
// Optional abort of a run is enabled by defining COUNTER_SCHED_ABORT_EN.
module counter_sched
  import counter_sched_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NREQ  = DEF_NREQ
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NREQ-1:0]             req,
  input  logic [NREQ-1:0][WIDTH-1:0]  req_limit,
  input  logic [NREQ-1:0]             req_dir,
  input  logic                        abort,
  output logic [NREQ-1:0]             grant,
  output logic                        busy,
  output logic [WIDTH-1:0]            cnt,
  output logic                        done,
  output logic [$clog2(NREQ)-1:0]     done_id,
  output logic                        done_abort
);

  localparam int IW = $clog2(NREQ);

  state_t           state;
  logic [IW-1:0]    ptr;
  logic [IW-1:0]    own_idx;
  logic [WIDTH-1:0] lim;
  logic             dir;
  logic [NREQ-1:0]  arb_gnt;
  logic [IW-1:0]    arb_idx;
  logic [WIDTH-1:0] term;
  logic             abort_hit;

`ifdef COUNTER_SCHED_ABORT_EN
  assign abort_hit = abort;
`else
  logic unused_abort;
  assign unused_abort = abort;
  assign abort_hit    = 1'b0;
`endif

  rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
    .req (req),
    .ptr (ptr),
    .gnt (arb_gnt),
    .idx (arb_idx)
  );

  assign busy = (state != IDLE);
  assign term = dir ? '0 : lim;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ptr        <= IW'(NREQ - 1);
      own_idx    <= '0;
      lim        <= '0;
      dir        <= 1'b0;
      grant      <= '0;
      cnt        <= '0;
      done       <= 1'b0;
      done_id    <= '0;
      done_abort <= 1'b0;
    end else begin
      done       <= 1'b0;
      done_abort <= 1'b0;
      case (state)
        IDLE: begin
          if (|req) begin
            state   <= LOAD;
            grant   <= arb_gnt;
            own_idx <= arb_idx;
            lim     <= req_limit[arb_idx];
            dir     <= req_dir[arb_idx];
          end
        end
        LOAD: begin
          if (abort_hit) begin
            state      <= DONE;
            done       <= 1'b1;
            done_id    <= own_idx;
            done_abort <= 1'b1;
          end else begin
            cnt   <= dir ? lim : '0;
            state <= RUN;
          end
        end
        RUN: begin
          if (abort_hit) begin
            state      <= DONE;
            done       <= 1'b1;
            done_id    <= own_idx;
            done_abort <= 1'b1;
          end else if (cnt == term) begin
            state   <= DONE;
            done    <= 1'b1;
            done_id <= own_idx;
          end else begin
            cnt <= dir ? cnt - WIDTH'(1) : cnt + WIDTH'(1);
          end
        end
        DONE: begin
          ptr   <= own_idx;
          grant <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_counter_sched.sv
// tb/tb_counter_sched.sv - directed self-checking bench for counter_sched
module tb_counter_sched;

  logic             clk;
  logic             rst;
  logic [3:0]       req;
  logic [3:0][7:0]  req_limit;
  logic [3:0]       req_dir;
  logic             abort;
  logic [3:0]       grant;
  logic             busy;
  logic [7:0]       cnt;
  logic             done;
  logic [1:0]       done_id;
  logic             done_abort;

  int checks = 0;
  int errors = 0;
  int n;

  counter_sched #(.WIDTH(8), .NREQ(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .req_limit  (req_limit),
    .req_dir    (req_dir),
    .abort      (abort),
    .grant      (grant),
    .busy       (busy),
    .cnt        (cnt),
    .done       (done),
    .done_id    (done_id),
    .done_abort (done_abort)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns ticks until done is seen, or -1 if the budget expires
  task automatic wait_done(output int cyc);
    cyc = 0;
    while (cyc < 400) begin
      tick();
      cyc++;
      if (done) break;
    end
    if (!done) cyc = -1;
  endtask

  initial begin
    rst = 1'b1; req = '0; req_limit = '0; req_dir = '0; abort = 1'b0;
    tick();
    tick();
    check("rst_grant", grant, 0);
    check("rst_busy", busy, 0);
    check("rst_cnt", cnt, 0);
    check("rst_done", done, 0);
    check("rst_done_id", done_id, 0);
    check("rst_done_abort", done_abort, 0);
    rst = 1'b0;

    // Single up run, limit 5
    req = 4'b0001; req_limit[0] = 8'd5; req_dir[0] = 1'b0;
    tick();
    check("up_grant", grant, 4'b0001);
    check("up_busy", busy, 1);
    tick();
    check("up_cnt0", cnt, 0);
    wait_done(n);
    check("up_lat", n + 2, 8);
    check("up_id", done_id, 0);
    check("up_cnt", cnt, 5);
    check("up_abort", done_abort, 0);
    req = '0;
    tick();
    check("up_idle_busy", busy, 0);
    check("up_idle_grant", grant, 0);
    check("up_idle_done", done, 0);
    check("up_idle_cnt", cnt, 5);

    // Down run, zero limit
    req = 4'b0100; req_limit[2] = 8'd0; req_dir[2] = 1'b1;
    wait_done(n);
    check("zero_lat", n, 3);
    check("zero_id", done_id, 2);
    check("zero_cnt", cnt, 0);
    req = '0;
    tick();

    // Fairness with all requesters held
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req = 4'b1111; req_limit = {8'd1, 8'd1, 8'd1, 8'd1}; req_dir = '0;
    for (int i = 0; i < 5; i++) begin
      wait_done(n);
      check("fair_lat", n, 4);
      check("fair_id", done_id, i % 4);
      tick();
      check("fair_idle", busy, 0);
    end
    req = '0;
    tick();

    // Reset mid-run
    req = 4'b0010; req_limit[1] = 8'd10;
    repeat (5) tick();
    check("mid_cnt", cnt, 3);
    rst = 1'b1; req = '0;
    tick();
    check("mid_busy", busy, 0);
    check("mid_cnt_rst", cnt, 0);
    check("mid_grant", grant, 0);
    check("mid_done", done, 0);
    rst = 1'b0;
    req = 4'b0011;
    tick();
    check("mid_next_grant", grant, 4'b0001);
    check("mid_next_done", done, 0);
    wait_done(n);
    check("mid_next_id", done_id, 0);
    req = '0;
    tick();

    // Down run; owner's inputs change after grant
    req = 4'b0010; req_limit[1] = 8'd3; req_dir[1] = 1'b1;
    tick();
    check("dn_grant", grant, 4'b0010);
    req_limit[1] = 8'd7; req_dir[1] = 1'b0;
    tick();
    check("dn_cnt0", cnt, 3);
    wait_done(n);
    check("dn_lat", n + 2, 6);
    check("dn_cnt", cnt, 0);
    check("dn_id", done_id, 1);
    req = '0;
    tick();

    // Abort in RUN at cnt=2
    req = 4'b0001; req_limit[0] = 8'd9; req_dir[0] = 1'b0;
    repeat (4) tick();
    check("ab_cnt", cnt, 2);
    abort = 1'b1;
    tick();
    abort = 1'b0;
`ifdef COUNTER_SCHED_ABORT_EN
    check("ab_done", done, 1);
    check("ab_flag", done_abort, 1);
    check("ab_cnt_held", cnt, 2);
`else
    check("ab_done", done, 0);
    wait_done(n);
    check("ab_lat", n + 5, 12);
    check("ab_cnt_full", cnt, 9);
    check("ab_flag", done_abort, 0);
`endif
    req = '0;
    tick();
    tick();

    // Maximum limit, no wrap
    req = 4'b1000; req_limit[3] = 8'd255; req_dir[3] = 1'b0;
    wait_done(n);
    check("max_lat", n, 258);
    check("max_cnt", cnt, 255);
    check("max_id", done_id, 3);
    req = '0;
    tick();
    check("max_idle_cnt", cnt, 255);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
